// File: rtl/calc_pkg.sv
// Shared constants for the stack ALU sequencer: opcodes, FSM encoding, error bit positions.
package calc_pkg;

  localparam int DATA_W = 32;

  typedef logic [3:0] op_t;

  localparam op_t OP_ADD = 4'b0001;
  localparam op_t OP_SUB = 4'b0010;
  localparam op_t OP_MUL = 4'b0100;
  localparam op_t OP_DIV = 4'b1000;
  localparam op_t OP_NOP = 4'b0000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  // err = {div0, arith_ovf, underflow, full}
  localparam int ERR_FULL      = 0;
  localparam int ERR_UNDERFLOW = 1;
  localparam int ERR_OVF       = 2;
  localparam int ERR_DIV0      = 3;

  function automatic logic op_is_valid(input op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/calc_stack_mem.sv
// Operand register file: DEPTH x 32, one write port, two asynchronous read ports.
module calc_stack_mem
  import calc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr_a,
  output logic [DATA_W-1:0]        rdata_a,
  input  logic [$clog2(DEPTH)-1:0] raddr_b,
  output logic [DATA_W-1:0]        rdata_b
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage is deliberately not reset; count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_r[raddr_a];
  assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/stack_alu_sequencer.sv
// Operand stack with a four-state sequencer that feeds an external ALU and writes its result back.
module stack_alu_sequencer
  import calc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_valid,
  input  logic [31:0]            push_data,
  input  logic                   op_valid,
  input  logic [3:0]             op,
  output logic                   ready,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [3:0]             alu_op,
  input  logic [31:0]            alu_y,
  input  logic                   alu_overflow,
  output logic [31:0]            top,
  output logic [$clog2(DEPTH):0] count,
  output logic [3:0]             err,
  input  logic                   clear_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]        state_r, state_nxt_s;
  logic [CW-1:0]     count_r, count_nxt_s;
  logic [3:0]        err_r, err_set_s;
  op_t               op_r;
  logic [31:0]       alu_a_r, alu_b_r, result_r;
  op_t               alu_op_r;
  logic              ready_r;
  logic              accept_op_s;
  logic              div0_s;
  logic [31:0]       exec_y_s;
  logic              wr_en_s;
  logic [AW-1:0]     wr_addr_s;
  logic [31:0]       wr_data_s;
  logic [AW-1:0]     rd_top_addr_s, rd_next_addr_s;
  logic [31:0]       rd_top_s, rd_next_s;

  // Index arithmetic wraps in AW bits, so count==DEPTH still addresses DEPTH-1.
  assign rd_top_addr_s  = count_r[AW-1:0] - AW'(1);
  assign rd_next_addr_s = count_r[AW-1:0] - AW'(2);

  calc_stack_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we      (wr_en_s),
    .waddr   (wr_addr_s),
    .wdata   (wr_data_s),
    .raddr_a (rd_top_addr_s),
    .rdata_a (rd_top_s),
    .raddr_b (rd_next_addr_s),
    .rdata_b (rd_next_s)
  );

  assign div0_s   = (op_r == OP_DIV) && (alu_b_r == 32'd0);
  assign exec_y_s = div0_s ? 32'd0 : alu_y;

  // Next-state, stack write port and error-set decode.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    err_set_s   = 4'b0000;
    accept_op_s = 1'b0;
    wr_en_s     = 1'b0;
    wr_addr_s   = count_r[AW-1:0];
    wr_data_s   = push_data;
    case (state_r)
      ST_IDLE: begin
        if (op_valid) begin
          if (!op_is_valid(op)) begin
            state_nxt_s = ST_IDLE;
          end else if (count_r < CW'(2)) begin
            err_set_s[ERR_UNDERFLOW] = 1'b1;
          end else begin
            state_nxt_s = ST_FETCH;
            accept_op_s = 1'b1;
          end
        end else if (push_valid) begin
          if (count_r == CW'(DEPTH)) begin
            err_set_s[ERR_FULL] = 1'b1;
          end else begin
            wr_en_s     = 1'b1;
            count_nxt_s = count_r + CW'(1);
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_nxt_s = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt_s         = ST_WRITE;
        err_set_s[ERR_DIV0] = div0_s;
        err_set_s[ERR_OVF]  = alu_overflow;
      end
      ST_WRITE: begin
        state_nxt_s = ST_IDLE;
        wr_en_s     = 1'b1;
        wr_addr_s   = rd_next_addr_s;
        wr_data_s   = result_r;
        count_nxt_s = count_r - CW'(1);
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, ALU operand/opcode registers and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      count_r  <= '0;
      err_r    <= 4'b0000;
      op_r     <= OP_NOP;
      alu_a_r  <= 32'd0;
      alu_b_r  <= 32'd0;
      alu_op_r <= OP_NOP;
      result_r <= 32'd0;
      ready_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      ready_r <= (state_nxt_s == ST_IDLE);
      // A new error in the same cycle wins over clear_err.
      err_r   <= (clear_err ? 4'b0000 : err_r) | err_set_s;
      if (accept_op_s) begin
        op_r <= op;
      end
      if (state_r == ST_FETCH) begin
        alu_b_r  <= rd_top_s;
        alu_a_r  <= rd_next_s;
        alu_op_r <= op_r;
      end else if (state_r == ST_EXEC) begin
        result_r <= exec_y_s;
        alu_op_r <= OP_NOP;
      end
    end
  end

  assign ready  = ready_r;
  assign alu_a  = alu_a_r;
  assign alu_b  = alu_b_r;
  assign alu_op = alu_op_r;
  assign count  = count_r;
  assign err    = err_r;
  assign top    = (count_r == CW'(0)) ? 32'd0 : rd_top_s;

endmodule
